// File: rtl/store_writeback_unit_pkg.sv
// Shared constants for the UT datapath store writeback path.
// Holds the store FSM encoding and default geometry.
package store_writeback_unit_pkg;

  localparam int SWU_ADDR_W    = 6;
  localparam int SWU_DATA_W    = 16;
  localparam int SWU_WR_CYCLES = 2;
  localparam int SWU_CNT_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_HOLD
  } swu_state_e;

endpackage

// File: rtl/store_writeback_unit_slot.sv
// One-entry pending store buffer for the writeback unit.
// A capture in the same cycle as a promotion wins and keeps it valid.
module store_pending_slot
  import store_writeback_unit_pkg::*;
#(
  parameter int ADDR_W = SWU_ADDR_W,
  parameter int DATA_W = SWU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (ce) begin
      if (wr) begin
        valid <= 1'b1;
        addr  <= wr_addr;
        data  <= wr_data;
      end else if (rd) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/store_writeback_unit.sv
// Store writeback sequencer: SETUP, WRITE burst, HOLD per store,
// with a one-entry pending slot and a sticky overflow flag.
module store_writeback_unit
  import store_writeback_unit_pkg::*;
#(
  parameter int ADDR_W    = SWU_ADDR_W,
  parameter int DATA_W    = SWU_DATA_W,
  parameter int WR_CYCLES = SWU_WR_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [DATA_W-1:0] data_UAL,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              store_busy,
  output logic              store_done,
  output logic              store_overflow
);

  localparam int CNT_W = SWU_CNT_W;

  swu_state_e       state_q;
  swu_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load_req;
  logic             load_pend;
  logic             slot_wr;
  logic             drop;
  logic             slot_valid;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_req  = 1'b0;
    load_pend = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // a slot filled during HOLD is drained from IDLE
        if (slot_valid) begin
          load_pend = 1'b1;
          state_d   = S_SETUP;
        end else if (store_req) begin
          load_req = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_WRITE;
        cnt_d   = CNT_W'(WR_CYCLES - 1);
      end
      S_WRITE: begin
        if (cnt_q == '0) state_d = S_HOLD;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_HOLD: begin
        if (slot_valid) begin
          load_pend = 1'b1;
          state_d   = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // the slot accepts when empty or being promoted this cycle
  assign slot_wr = store_req
                 & ((state_q != S_IDLE) | slot_valid)
                 & (~slot_valid | load_pend);
  assign drop    = store_req & slot_valid & ~load_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      mem_addr       <= '0;
      mem_data_out   <= '0;
      store_overflow <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_req) begin
        mem_addr     <= store_addr;
        mem_data_out <= data_UAL;
      end else if (load_pend) begin
        mem_addr     <= slot_addr;
        mem_data_out <= slot_data;
      end
      if (drop) store_overflow <= 1'b1;
    end
  end

  store_pending_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .wr      (slot_wr),
    .rd      (load_pend),
    .wr_addr (store_addr),
    .wr_data (data_UAL),
    .valid   (slot_valid),
    .addr    (slot_addr),
    .data    (slot_data)
  );

  assign mem_en     = (state_q != S_IDLE);
  assign mem_we     = (state_q == S_WRITE);
  assign store_done = (state_q == S_HOLD);
  assign store_busy = (state_q != S_IDLE) | slot_valid;

endmodule
